// File: rtl/plab3_mem_pkg.sv
// Shared encodings and field widths for the line-granularity memory
// request/response interface (32-bit address, 128-bit line data).
package plab3_mem_pkg;

  localparam int unsigned MEM_TYPE_NBITS  = 3;
  localparam int unsigned MEM_ADDR_NBITS  = 32;
  localparam int unsigned MEM_LEN_NBITS   = 4;
  localparam int unsigned MEM_DATA_NBITS  = 128;
  localparam int unsigned MEM_LINE_NBYTES = 16;

  localparam logic [MEM_TYPE_NBITS-1:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [MEM_TYPE_NBITS-1:0] MEM_TYPE_WRITE = 3'd1;
  localparam logic [MEM_TYPE_NBITS-1:0] MEM_TYPE_INIT  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  function automatic int unsigned mem_req_nbits(input int unsigned opaque_nbits);
    return MEM_TYPE_NBITS + opaque_nbits + MEM_ADDR_NBITS + MEM_LEN_NBITS + MEM_DATA_NBITS;
  endfunction

  function automatic int unsigned mem_resp_nbits(input int unsigned opaque_nbits);
    return MEM_TYPE_NBITS + opaque_nbits + MEM_LEN_NBITS + MEM_DATA_NBITS;
  endfunction

endpackage

// File: rtl/plab3_mem_line_store.sv
// Line-organised backing store: synchronous byte-masked write, combinational read.
// Contents are deliberately not reset.
module plab3_mem_line_store
  import plab3_mem_pkg::*;
#(
  parameter int p_nlines = 256,
  localparam int c_idx_w = $clog2(p_nlines)
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [c_idx_w-1:0]         i_idx,
  input  logic [MEM_LINE_NBYTES-1:0] i_be,
  input  logic [MEM_DATA_NBITS-1:0]  i_wdata,
  output logic [MEM_DATA_NBITS-1:0]  o_rdata
);

  logic [MEM_DATA_NBITS-1:0] r_mem [p_nlines];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(MEM_LINE_NBYTES); b++) begin
        if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/plab3_mem_line_mem_responder.sv
// Memory-side responder for the L1 memreq/memresp interface: one line
// request at a time, fixed extra latency, sticky out-of-range flag.
//
// state | meaning
// IDLE  | ready to accept a request (once out of reset)
// WAIT  | request accepted, counting p_latency cycles
// RESP  | response valid, held until memresp_rdy
module plab3_mem_line_mem_responder
  import plab3_mem_pkg::*;
#(
  parameter int p_mem_nbytes   = 4096,
  parameter int p_opaque_nbits = 8,
  parameter int p_latency      = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       memreq_val,
  output logic                                       memreq_rdy,
  input  logic [mem_req_nbits(p_opaque_nbits)-1:0]   memreq_msg,
  output logic                                       memresp_val,
  input  logic                                       memresp_rdy,
  output logic [mem_resp_nbits(p_opaque_nbits)-1:0]  memresp_msg,
  output logic                                       err_oob
);

  localparam int c_nlines = p_mem_nbytes / int'(MEM_LINE_NBYTES);
  localparam int c_idx_w  = $clog2(c_nlines);
  localparam logic [7:0] c_cnt_last = 8'(p_latency - 1);

  logic [MEM_TYPE_NBITS-1:0]  w_req_type;
  logic [p_opaque_nbits-1:0]  w_req_opaque;
  logic [MEM_ADDR_NBITS-1:0]  w_req_addr;
  logic [MEM_LEN_NBITS-1:0]   w_req_len;
  logic [MEM_DATA_NBITS-1:0]  w_req_data;
  logic [MEM_DATA_NBITS-1:0]  w_line;
  logic [MEM_LINE_NBYTES-1:0] w_bmask;
  logic                       w_accept;
  logic                       w_is_wr;
  logic                       w_oob;

  mem_state_e                 r_state, w_state_next;
  logic [7:0]                 r_cnt, w_cnt_next;
  logic                       r_live;
  logic [MEM_TYPE_NBITS-1:0]  r_type;
  logic [p_opaque_nbits-1:0]  r_opaque;
  logic [MEM_LEN_NBITS-1:0]   r_len;
  logic [MEM_DATA_NBITS-1:0]  r_data;
  logic                       r_oob;

  assign {w_req_type, w_req_opaque, w_req_addr, w_req_len, w_req_data} = memreq_msg;

  // r_live keeps memreq_rdy low while reset is asserted even though state is IDLE
  assign memreq_rdy  = r_live && (r_state == ST_IDLE);
  assign memresp_val = (r_state == ST_RESP);
  assign memresp_msg = {r_type, r_opaque, r_len, r_data};
  assign err_oob     = r_oob;

  assign w_accept = memreq_val && memreq_rdy;
  assign w_is_wr  = (w_req_type == MEM_TYPE_WRITE) || (w_req_type == MEM_TYPE_INIT);
  assign w_oob    = (w_req_addr >= MEM_ADDR_NBITS'(p_mem_nbytes));

  always_comb begin
    w_bmask = '1;
    if (w_req_len != '0) w_bmask = (16'd1 << w_req_len) - 16'd1;
  end

  plab3_mem_line_store #(.p_nlines(c_nlines)) u_store (
    .clk     (clk),
    .i_we    (w_accept && w_is_wr && !w_oob),
    .i_idx   (w_req_addr[c_idx_w+3:4]),
    .i_be    (w_bmask),
    .i_wdata (w_req_data),
    .o_rdata (w_line)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_next   = '0;
          w_state_next = (p_latency == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == c_cnt_last) w_state_next = ST_RESP;
        else                     w_cnt_next   = r_cnt + 8'd1;
      end
      ST_RESP: begin
        if (memresp_rdy) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_live   <= 1'b0;
      r_type   <= '0;
      r_opaque <= '0;
      r_len    <= '0;
      r_data   <= '0;
      r_oob    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_type   <= w_req_type;
        r_opaque <= w_req_opaque;
        r_len    <= w_req_len;
        r_data   <= (w_is_wr || w_oob) ? '0 : w_line;
        if (w_oob) r_oob <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_plab3_mem_line_mem_responder.sv
// Bench for the line memory responder: directed scenarios plus randomized
// traffic against a byte-addressed memory model.
module tb_plab3_mem_line_mem_responder;

  localparam int NB  = 4096;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         memreq_val = 1'b0;
  logic         memreq_rdy;
  logic [174:0] memreq_msg = '0;
  logic         memresp_val;
  logic         memresp_rdy = 1'b0;
  logic [142:0] memresp_msg;
  logic         err_oob;

  logic [7:0] model_mem [NB];
  bit         model_oob = 1'b0;
  int         tests_run = 0;
  int         fails = 0;

  plab3_mem_line_mem_responder #(
    .p_mem_nbytes(NB), .p_opaque_nbits(8), .p_latency(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [127:0] model_read(input logic [31:0] a);
    logic [127:0] r;
    int base;
    r = '0;
    if (a >= 32'(NB)) return r;
    base = int'(a) & ~15;
    for (int b = 0; b < 16; b++) r[b*8 +: 8] = model_mem[base+b];
    return r;
  endfunction

  // Applies one request to the model and returns the expected response word
  function automatic logic [142:0] model_txn(input logic [2:0] t, input logic [7:0] op,
                                             input logic [31:0] a, input logic [3:0] l,
                                             input logic [127:0] d);
    logic [127:0] rd;
    int base, n;
    rd = '0;
    if (a >= 32'(NB)) model_oob = 1'b1;
    if (t == 3'd1 || t == 3'd2) begin
      if (a < 32'(NB)) begin
        base = int'(a) & ~15;
        n = (l == 4'd0) ? 16 : int'(l);
        for (int b = 0; b < n; b++) model_mem[base+b] = d[b*8 +: 8];
      end
    end else begin
      rd = model_read(a);
    end
    return {t, op, l, rd};
  endfunction

  task automatic do_txn(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                        input logic [3:0] l, input logic [127:0] d,
                        output logic [142:0] resp, output int lat,
                        output bit busy_rdy, output bit tmo);
    int n;
    resp = '0; lat = 0; busy_rdy = 1'b0; tmo = 1'b0;
    @(negedge clk);
    memreq_msg  = {t, op, a, l, d};
    memreq_val  = 1'b1;
    memresp_rdy = 1'b1;
    n = 0;
    while (!memreq_rdy && n < 100) begin @(negedge clk); n++; end
    if (!memreq_rdy) begin memreq_val = 1'b0; tmo = 1'b1; return; end
    @(posedge clk);
    @(negedge clk);
    memreq_val = 1'b0;
    lat = 1;
    while (!memresp_val && lat < 300) begin
      if (memreq_rdy) busy_rdy = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!memresp_val) begin tmo = 1'b1; return; end
    if (memreq_rdy) busy_rdy = 1'b1;
    resp = memresp_msg;
    @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (memreq_rdy !== 1'b0) begin fails++; $display("FAIL rst_req_rdy got=%b exp=0", memreq_rdy); end
    tests_run++;
    if (memresp_val !== 1'b0) begin fails++; $display("FAIL rst_resp_val got=%b exp=0", memresp_val); end
    tests_run++;
    if (err_oob !== 1'b0) begin fails++; $display("FAIL rst_err_oob got=%b exp=0", err_oob); end
    tests_run++;
    if (memresp_msg !== 143'd0) begin fails++; $display("FAIL rst_resp_msg got=%h exp=0", memresp_msg); end
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (memreq_rdy !== 1'b1) begin fails++; $display("FAIL rst_release_rdy got=%b exp=1", memreq_rdy); end
  endtask

  task automatic test_write_read();
    logic [142:0] r, e;
    logic [127:0] d;
    int lat; bit busy, tmo;
    d = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    e = model_txn(3'd1, 8'h5A, 32'h100, 4'd0, d);
    do_txn(3'd1, 8'h5A, 32'h100, 4'd0, d, r, lat, busy, tmo);
    tests_run++;
    if (tmo || r !== {3'd1, 8'h5A, 4'd0, 128'd0}) begin
      fails++; $display("FAIL wr_resp got=%h exp=%h tmo=%0d", r, {3'd1, 8'h5A, 4'd0, 128'd0}, tmo);
    end
    e = model_txn(3'd0, 8'hA5, 32'h100, 4'd0, 128'd0);
    do_txn(3'd0, 8'hA5, 32'h100, 4'd0, 128'd0, r, lat, busy, tmo);
    tests_run++;
    if (tmo || r !== {3'd0, 8'hA5, 4'd0, d}) begin
      fails++; $display("FAIL rd_resp got=%h exp=%h tmo=%0d", r, {3'd0, 8'hA5, 4'd0, d}, tmo);
    end
  endtask

  task automatic test_latency();
    logic [142:0] r, e;
    int lat; bit busy, tmo;
    e = model_txn(3'd0, 8'h11, 32'h104, 4'd0, 128'd0);
    do_txn(3'd0, 8'h11, 32'h104, 4'd0, 128'd0, r, lat, busy, tmo);
    tests_run++;
    if (tmo || lat != 1 + LAT) begin fails++; $display("FAIL latency got=%0d exp=%0d", lat, 1 + LAT); end
    tests_run++;
    if (busy) begin fails++; $display("FAIL busy_rdy got=1 exp=0"); end
    tests_run++;
    if (r !== e) begin fails++; $display("FAIL lat_rd_data got=%h exp=%h", r, e); end
  endtask

  task automatic test_stall();
    logic [142:0] first, e, r;
    int n, lat; bit busy, tmo;
    e = model_txn(3'd0, 8'h33, 32'h100, 4'd0, 128'd0);
    @(negedge clk);
    memresp_rdy = 1'b0;
    memreq_msg  = {3'd0, 8'h33, 32'h100, 4'd0, 128'd0};
    memreq_val  = 1'b1;
    n = 0;
    while (!memreq_rdy && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    // a competing write is held valid during the stall and must never be taken
    memreq_msg = {3'd1, 8'h44, 32'h100, 4'd0, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF};
    n = 0;
    while (!memresp_val && n < 50) begin @(negedge clk); n++; end
    first = memresp_msg;
    tests_run++;
    if (!memresp_val || first !== e) begin
      fails++; $display("FAIL stall_first got=%h exp=%h val=%b", first, e, memresp_val);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (memresp_val !== 1'b1 || memresp_msg !== first || memreq_rdy !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold cyc=%0d val=%b rdy=%b msg=%h exp=%h", i, memresp_val, memreq_rdy, memresp_msg, first);
      end
    end
    memreq_val  = 1'b0;
    memresp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (memresp_val !== 1'b0 || memreq_rdy !== 1'b1) begin
      fails++; $display("FAIL stall_release val=%b rdy=%b exp val=0 rdy=1", memresp_val, memreq_rdy);
    end
    e = model_txn(3'd0, 8'h34, 32'h100, 4'd0, 128'd0);
    do_txn(3'd0, 8'h34, 32'h100, 4'd0, 128'd0, r, lat, busy, tmo);
    tests_run++;
    if (tmo || r !== e) begin fails++; $display("FAIL stall_no_accept got=%h exp=%h", r, e); end
  endtask

  task automatic test_partial();
    logic [142:0] r, e;
    int lat; bit busy, tmo;
    e = model_txn(3'd1, 8'h01, 32'h200, 4'd0, '1);
    do_txn(3'd1, 8'h01, 32'h200, 4'd0, '1, r, lat, busy, tmo);
    e = model_txn(3'd1, 8'h02, 32'h200, 4'd4, 128'hA5A5A5A5_0BADF00D_CAFEBABE_12345678);
    do_txn(3'd1, 8'h02, 32'h200, 4'd4, 128'hA5A5A5A5_0BADF00D_CAFEBABE_12345678, r, lat, busy, tmo);
    e = model_txn(3'd0, 8'h03, 32'h207, 4'd0, 128'd0);
    do_txn(3'd0, 8'h03, 32'h207, 4'd0, 128'd0, r, lat, busy, tmo);
    tests_run++;
    if (tmo || r[127:0] !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_12345678) begin
      fails++; $display("FAIL partial_len4 got=%h exp=ffffffffffffffffffffffff12345678", r[127:0]);
    end
    tests_run++;
    if (r !== e) begin fails++; $display("FAIL partial_model got=%h exp=%h", r, e); end
  endtask

  task automatic test_oob();
    logic [142:0] r, e;
    int lat; bit busy, tmo;
    tests_run++;
    if (err_oob !== 1'b0) begin fails++; $display("FAIL oob_pre got=%b exp=0", err_oob); end
    e = model_txn(3'd1, 8'h21, 32'h0, 4'd0, 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C);
    do_txn(3'd1, 8'h21, 32'h0, 4'd0, 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C, r, lat, busy, tmo);
    e = model_txn(3'd0, 8'h22, 32'h2000, 4'd0, 128'd0);
    do_txn(3'd0, 8'h22, 32'h2000, 4'd0, 128'd0, r, lat, busy, tmo);
    tests_run++;
    if (tmo || r !== {3'd0, 8'h22, 4'd0, 128'd0}) begin fails++; $display("FAIL oob_read got=%h exp=%h", r, e); end
    tests_run++;
    if (err_oob !== 1'b1) begin fails++; $display("FAIL oob_flag got=%b exp=1", err_oob); end
    e = model_txn(3'd1, 8'h23, 32'h1000, 4'd0, '1);
    do_txn(3'd1, 8'h23, 32'h1000, 4'd0, '1, r, lat, busy, tmo);
    e = model_txn(3'd0, 8'h24, 32'h0, 4'd0, 128'd0);
    do_txn(3'd0, 8'h24, 32'h0, 4'd0, 128'd0, r, lat, busy, tmo);
    tests_run++;
    if (tmo || r !== e) begin fails++; $display("FAIL oob_no_write got=%h exp=%h", r, e); end
    tests_run++;
    if (err_oob !== 1'b1) begin fails++; $display("FAIL oob_sticky got=%b exp=1", err_oob); end
  endtask

  task automatic test_reset_mid();
    logic [142:0] r, e;
    int lat, n; bit busy, tmo;
    e = model_txn(3'd1, 8'h31, 32'h300, 4'd0, 128'h13579BDF_2468ACE0_FEDCBA98_76543210);
    do_txn(3'd1, 8'h31, 32'h300, 4'd0, 128'h13579BDF_2468ACE0_FEDCBA98_76543210, r, lat, busy, tmo);
    @(negedge clk);
    memreq_msg = {3'd0, 8'h32, 32'h300, 4'd0, 128'd0};
    memreq_val = 1'b1;
    n = 0;
    while (!memreq_rdy && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    memreq_val = 1'b0;
    reset = 1'b0;
    #1;
    tests_run++;
    if (memresp_val !== 1'b0 || memreq_rdy !== 1'b0) begin
      fails++; $display("FAIL midrst_assert val=%b rdy=%b exp 0 0", memresp_val, memreq_rdy);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (memresp_val !== 1'b0) begin fails++; $display("FAIL midrst_noresp got=%b exp=0", memresp_val); end
    reset = 1'b1;
    model_oob = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (memreq_rdy !== 1'b1 || memresp_val !== 1'b0 || err_oob !== 1'b0) begin
      fails++; $display("FAIL midrst_release rdy=%b val=%b oob=%b exp 1 0 0", memreq_rdy, memresp_val, err_oob);
    end
    e = model_txn(3'd0, 8'h33, 32'h300, 4'd0, 128'd0);
    do_txn(3'd0, 8'h33, 32'h300, 4'd0, 128'd0, r, lat, busy, tmo);
    tests_run++;
    if (tmo || r !== e) begin fails++; $display("FAIL midrst_persist got=%h exp=%h", r, e); end
  endtask

  task automatic test_random();
    logic [142:0] r, e;
    logic [2:0]   t;
    logic [7:0]   op;
    logic [31:0]  a;
    logic [3:0]   l;
    logic [127:0] d;
    int lat, sel; bit busy, tmo;
    for (int i = 0; i < NB / 16; i++) begin
      d  = {$urandom, $urandom, $urandom, $urandom};
      op = 8'($urandom_range(0, 255));
      a  = 32'(i * 16);
      e  = model_txn(3'd2, op, a, 4'd0, d);
      do_txn(3'd2, op, a, 4'd0, d, r, lat, busy, tmo);
      tests_run++;
      if (tmo || r !== e) begin fails++; $display("FAIL rnd_init line=%0d got=%h exp=%h", i, r, e); end
    end
    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4)       t = 3'd0;
      else if (sel < 6)  t = 3'd1;
      else if (sel < 8)  t = 3'd2;
      else               t = 3'($urandom_range(3, 7));
      if ($urandom_range(0, 14) == 0) a = 32'(NB) + $urandom_range(0, 32'hFFFF);
      else                            a = 32'($urandom_range(0, NB - 1));
      l  = 4'($urandom_range(0, 15));
      op = 8'($urandom_range(0, 255));
      d  = {$urandom, $urandom, $urandom, $urandom};
      e  = model_txn(t, op, a, l, d);
      do_txn(t, op, a, l, d, r, lat, busy, tmo);
      tests_run++;
      if (tmo || r !== e) begin
        fails++; $display("FAIL rnd_op i=%0d t=%0d a=%h l=%0d got=%h exp=%h", i, t, a, l, r, e);
      end
      tests_run++;
      if (lat != 1 + LAT || busy) begin
        fails++; $display("FAIL rnd_timing i=%0d lat=%0d exp=%0d busy=%0d", i, lat, 1 + LAT, busy);
      end
    end
    tests_run++;
    if (err_oob !== model_oob) begin fails++; $display("FAIL rnd_err_oob got=%b exp=%b", err_oob, model_oob); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency();
    test_stall();
    test_partial();
    test_oob();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
